dcache_ctrl: RTL and testbench
==============================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have one parameter: INDEX_BITS, default 4, giving the number of index bits (2^INDEX_BITS lines, one 16-bit word per line).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  asynchronous active-low reset.
REQ-005 Port: Rd  input  1  read request from the memory stage.
REQ-006 Port: Wr  input  1  write request from the memory stage.
REQ-007 Port: Addr  input  16  byte address; word index = Addr[INDEX_BITS:1]; tag = Addr[15:INDEX_BITS+1].
REQ-008 Port: DataIn  input  16  store data.
REQ-009 Port: DataOut  output  16  load data, valid when Done=1 for a read.
REQ-010 Port: Done  output  1  one-cycle completion pulse.
REQ-011 Port: Stall  output  1  busy; the pipeline holds the memory stage.
REQ-012 Port: CacheHit  output  1  qualifies Done; 1 = completed without a backing access.
REQ-013 Port: Err  output  1  one-cycle illegal-request pulse.
REQ-014 Port: mem_req  output  1  backing-memory request, held until mem_ack.
REQ-015 Port: mem_wr  output  1  1 = backing write, 0 = backing read; stable while mem_req=1.
REQ-016 Port: mem_addr  output  16  backing word address (bit 0 = 0); stable while mem_req=1.
REQ-017 Port: mem_wdata  output  16  backing write data; stable while mem_req=1.
REQ-018 Port: mem_rdata  input  16  backing read data, valid with mem_ack.
REQ-019 Port: mem_ack  input  1  single-cycle acknowledge from backing memory.

Function
REQ-020 Storage SHALL be per line: valid, dirty, tag, data; policy write-back, write-allocate.
REQ-021 FSM states SHALL be IDLE, WB (write victim), FILL (read line), DONE.
REQ-022 In IDLE, a request (Rd^Wr, Addr[0]=0) SHALL be latched (addr, data, rd/wr) at the clock edge; Rd&Wr=1 or Addr[0]=1 SHALL instead pulse Err next cycle, with no state change.
REQ-023 A hit (valid & tag match) SHALL go to DONE: Done=1, CacheHit=1 one cycle after acceptance; a write hit updates data and sets dirty.
REQ-024 A miss with valid&dirty victim SHALL go to WB: mem_req=1, mem_wr=1, mem_addr={victim tag, index, 1'b0}, mem_wdata=victim data; on mem_ack go to FILL.
REQ-025 A miss with clean or invalid victim SHALL go directly to FILL.
REQ-026 FILL SHALL drive mem_req=1, mem_wr=0, mem_addr=latched address; on mem_ack install the line (valid=1, tag, mem_rdata, dirty=0), then go to DONE.
REQ-027 A write miss SHALL, on the fill edge, merge DataIn into the line and set dirty=1.
REQ-028 DONE SHALL last exactly one cycle (Done=1, CacheHit=0 on a miss path) and return to IDLE.
REQ-029 DataOut SHALL equal the line data in DONE for reads; otherwise it is 0.
REQ-030 Stall SHALL be 1 in WB, FILL, and the cycle after acceptance until DONE; Stall=0 in DONE and IDLE.
REQ-031 Rd/Wr asserted while not in IDLE SHALL be ignored, not queued.
REQ-032 mem_ack outside WB/FILL SHALL be ignored.

Reset
REQ-033 rst=0 SHALL, asynchronously, clear all valid and dirty bits, force IDLE, and drive Done, Stall, CacheHit, Err, mem_req, mem_wr to 0 and DataOut, mem_addr, mem_wdata to 0.
REQ-034 Reset asserted mid-WB or mid-FILL SHALL abandon the transaction; the pending request is lost and no line is updated.

Verification
REQ-035 After reset, Rd Addr=0x0010, mem_ack 3 cycles later with mem_rdata=0xBEEF -> FILL read at 0x0010, then Done=1, CacheHit=0, DataOut=0xBEEF.
REQ-036 Repeat Rd 0x0010 -> Done=1, CacheHit=1, DataOut=0xBEEF one cycle after acceptance, mem_req stays 0.
REQ-037 Wr 0x0010 DataIn=0x1234 (hit), then Rd 0x0030 (same index, INDEX_BITS=4) -> WB write 0x0010/0x1234, then FILL read 0x0030.
REQ-038 Rd=Wr=1, and separately Rd with Addr=0x0011 -> Err pulse 1 cycle, Stall=0, mem_req=0, no Done.
REQ-039 rst=0 during FILL -> outputs zeroed immediately; a subsequent Rd to the same address misses (CacheHit=0).
REQ-040 Wr miss 0x0042 DataIn=0x00AA with clean victim -> FILL, Done, CacheHit=0; subsequent Rd 0x0042 hits, DataOut=0x00AA.

Source files
------------

// File: rtl/dcache_ctrl_if.sv
// Memory-stage and backing-memory signals of the data cache controller.
// The cache takes the slave view; the pipeline/memory side is the master.
interface dcache_ctrl_if;
    logic        Rd;
    logic        Wr;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        Err;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  Rd, Wr, Addr, DataIn, mem_rdata, mem_ack,
        output DataOut, Done, Stall, CacheHit, Err,
        output mem_req, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output Rd, Wr, Addr, DataIn, mem_rdata, mem_ack,
        input  DataOut, Done, Stall, CacheHit, Err,
        input  mem_req, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller.
// One 16-bit word per line; blocking backing-memory handshake.
module dcache_ctrl #(
    parameter int INDEX_BITS = 4
) (
    input  logic         clk,
    input  logic         rst,
    dcache_ctrl_if.slave bus
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TW    = 15 - INDEX_BITS;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WB   = 2'd1;
    localparam logic [1:0] FILL = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [15:0]           addr_q;
    logic [15:0]           din_q;
    logic                  rd_q;
    logic                  hit_q;
    logic                  err_q;
    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      dirty_q;
    logic [TW-1:0]         tag_mem  [LINES];
    logic [15:0]           data_mem [LINES];

    logic [INDEX_BITS-1:0] in_idx;
    logic [TW-1:0]         in_tag;
    logic [INDEX_BITS-1:0] q_idx;
    logic [TW-1:0]         q_tag;
    logic                  req_ok;
    logic                  req_bad;
    logic                  accept;
    logic                  in_hit;
    logic                  fill_ack;

    assign in_idx   = bus.Addr[INDEX_BITS:1];
    assign in_tag   = bus.Addr[15:INDEX_BITS+1];
    assign q_idx    = addr_q[INDEX_BITS:1];
    assign q_tag    = addr_q[15:INDEX_BITS+1];
    assign req_ok   = (bus.Rd ^ bus.Wr) && !bus.Addr[0];
    assign req_bad  = (bus.Rd && bus.Wr)
                   || ((bus.Rd || bus.Wr) && bus.Addr[0]);
    assign accept   = (state_q == IDLE) && req_ok;
    assign in_hit   = valid_q[in_idx]
                   && (tag_mem[in_idx] == in_tag);
    assign fill_ack = (state_q == FILL) && bus.mem_ack;

    // Next-state selection for the miss/hit sequencing.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_hit)
                        state_d = DONE;
                    else if (valid_q[in_idx] && dirty_q[in_idx])
                        state_d = WB;
                    else
                        state_d = FILL;
                end
            end
            WB:   if (bus.mem_ack) state_d = FILL;
            FILL: if (bus.mem_ack) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state, request latch and per-line valid/dirty flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            din_q   <= '0;
            rd_q    <= 1'b0;
            hit_q   <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == IDLE) && req_bad;
            if (accept) begin
                addr_q <= bus.Addr;
                din_q  <= bus.DataIn;
                rd_q   <= bus.Rd;
                hit_q  <= in_hit;
                if (in_hit && bus.Wr)
                    dirty_q[in_idx] <= 1'b1;
            end
            if (fill_ack) begin
                valid_q[q_idx] <= 1'b1;
                dirty_q[q_idx] <= !rd_q;
            end
        end
    end

    // Tag/data storage; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (accept && in_hit && bus.Wr)
                data_mem[in_idx] <= bus.DataIn;
            if (fill_ack) begin
                tag_mem[q_idx]  <= q_tag;
                data_mem[q_idx] <= rd_q ? bus.mem_rdata : din_q;
            end
        end
    end

    // Outputs decoded from state so reset clears them at once.
    always_comb begin
        bus.Done      = (state_q == DONE);
        bus.CacheHit  = (state_q == DONE) && hit_q;
        bus.Stall     = (state_q == WB) || (state_q == FILL);
        bus.Err       = err_q;
        bus.mem_req   = bus.Stall;
        bus.mem_wr    = (state_q == WB);
        bus.DataOut   = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if ((state_q == DONE) && rd_q)
            bus.DataOut = data_mem[q_idx];
        if (state_q == WB) begin
            bus.mem_addr  = {tag_mem[q_idx], q_idx, 1'b0};
            bus.mem_wdata = data_mem[q_idx];
        end else if (state_q == FILL) begin
            bus.mem_addr = addr_q;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed, table-driven bench for dcache_ctrl.
// Expected values are hand-computed for INDEX_BITS=4.
module tb_dcache_ctrl;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    dcache_ctrl_if bus ();

    dcache_ctrl #(.INDEX_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        int          dly;
        logic        err;
        logic        wb;
        logic [15:0] wb_addr;
        logic [15:0] wb_data;
        logic        fill;
        logic [15:0] fill_addr;
        logic [15:0] rdata;
        logic        hit;
        logic [15:0] dout;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(
        logic rd, logic wr, logic [15:0] addr, logic [15:0] din,
        int dly, logic err, logic wb, logic [15:0] wb_addr,
        logic [15:0] wb_data, logic fill, logic [15:0] fill_addr,
        logic [15:0] rdata, logic hit, logic [15:0] dout);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.din = din;
        v.dly = dly; v.err = err; v.wb = wb;
        v.wb_addr = wb_addr; v.wb_data = wb_data;
        v.fill = fill; v.fill_addr = fill_addr; v.rdata = rdata;
        v.hit = hit; v.dout = dout;
        return v;
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_after(int dly, logic [15:0] rdata, string tag);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk({tag, " req held"}, 16'(bus.mem_req), 16'd1);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0;
    endtask

    task automatic run(int n, vec_t v);
        string t;
        t = $sformatf("v%0d", n);
        bus.Rd     = v.rd;
        bus.Wr     = v.wr;
        bus.Addr   = v.addr;
        bus.DataIn = v.din;
        tick();
        bus.Rd = 1'b0;
        bus.Wr = 1'b0;
        if (v.err) begin
            chk({t, " err"},   16'(bus.Err), 16'd1);
            chk({t, " stall"}, 16'(bus.Stall), 16'd0);
            chk({t, " req"},   16'(bus.mem_req), 16'd0);
            chk({t, " done"},  16'(bus.Done), 16'd0);
            tick();
            chk({t, " err end"}, 16'(bus.Err), 16'd0);
            chk({t, " no done"}, 16'(bus.Done), 16'd0);
            return;
        end
        if (v.wb) begin
            chk({t, " wb stall"}, 16'(bus.Stall), 16'd1);
            chk({t, " wb req"},   16'(bus.mem_req), 16'd1);
            chk({t, " wb wr"},    16'(bus.mem_wr), 16'd1);
            chk({t, " wb addr"},  bus.mem_addr, v.wb_addr);
            chk({t, " wb data"},  bus.mem_wdata, v.wb_data);
            ack_after(v.dly, 16'h0, {t, " wb"});
        end
        if (v.fill) begin
            chk({t, " fill stall"}, 16'(bus.Stall), 16'd1);
            chk({t, " fill req"},   16'(bus.mem_req), 16'd1);
            chk({t, " fill wr"},    16'(bus.mem_wr), 16'd0);
            chk({t, " fill addr"},  bus.mem_addr, v.fill_addr);
            ack_after(v.dly, v.rdata, {t, " fill"});
        end
        chk({t, " done"},  16'(bus.Done), 16'd1);
        chk({t, " hit"},   16'(bus.CacheHit), 16'(v.hit));
        chk({t, " dout"},  bus.DataOut, v.dout);
        chk({t, " stall"}, 16'(bus.Stall), 16'd0);
        chk({t, " req"},   16'(bus.mem_req), 16'd0);
        tick();
        chk({t, " done end"}, 16'(bus.Done), 16'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        bus.Rd = 0; bus.Wr = 0; bus.Addr = 0; bus.DataIn = 0;
        bus.mem_ack = 0; bus.mem_rdata = 0;
        rst = 1'b0;

        //          rd wr addr     din    dly err wb wb_addr  wb_data fill faddr   rdata   hit dout
        vecs[0]  = mk(1, 0, 16'h0010, 16'h0000, 3, 0, 0, 16'h0000, 16'h0000, 1, 16'h0010, 16'hBEEF, 0, 16'hBEEF);
        vecs[1]  = mk(1, 0, 16'h0010, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'hBEEF);
        vecs[2]  = mk(0, 1, 16'h0010, 16'h1234, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0000);
        vecs[3]  = mk(1, 0, 16'h0030, 16'h0000, 1, 0, 1, 16'h0010, 16'h1234, 1, 16'h0030, 16'h5555, 0, 16'h5555);
        vecs[4]  = mk(1, 0, 16'h0010, 16'h0000, 2, 0, 0, 16'h0000, 16'h0000, 1, 16'h0010, 16'h1234, 0, 16'h1234);
        vecs[5]  = mk(0, 1, 16'h0042, 16'h00AA, 1, 0, 0, 16'h0000, 16'h0000, 1, 16'h0042, 16'h7777, 0, 16'h0000);
        vecs[6]  = mk(1, 0, 16'h0042, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h00AA);
        vecs[7]  = mk(1, 1, 16'h0010, 16'h0000, 0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        vecs[8]  = mk(1, 0, 16'h0011, 16'h0000, 0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        vecs[9]  = mk(0, 1, 16'h0002, 16'hCAFE, 0, 0, 1, 16'h0042, 16'h00AA, 1, 16'h0002, 16'h1111, 0, 16'h0000);
        vecs[10] = mk(1, 0, 16'h0002, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'hCAFE);

        // Reset state while held.
        #12;
        chk("rst done",  16'(bus.Done), 16'd0);
        chk("rst stall", 16'(bus.Stall), 16'd0);
        chk("rst err",   16'(bus.Err), 16'd0);
        chk("rst req",   16'(bus.mem_req), 16'd0);
        chk("rst maddr", bus.mem_addr, 16'h0);
        chk("rst dout",  bus.DataOut, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 11; i++)
            run(i, vecs[i]);

        // Requests during a fill are dropped, not queued.
        bus.Rd   = 1'b1;
        bus.Addr = 16'h0060;
        tick();
        bus.Addr = 16'h0010;
        chk("busy fill addr", bus.mem_addr, 16'h0060);
        tick();
        chk("busy addr held", bus.mem_addr, 16'h0060);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h6060;
        tick();
        bus.Rd      = 1'b0;
        bus.mem_ack = 1'b0;
        chk("busy done", 16'(bus.Done), 16'd1);
        chk("busy dout", bus.DataOut, 16'h6060);
        tick();
        chk("busy no queue req",  16'(bus.mem_req), 16'd0);
        chk("busy no queue done", 16'(bus.Done), 16'd0);

        // Stray ack while idle has no effect.
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("stray ack req",  16'(bus.mem_req), 16'd0);
        chk("stray ack done", 16'(bus.Done), 16'd0);
        run(11, mk(1, 0, 16'h0060, 16'h0, 0, 0, 0, 16'h0, 16'h0,
                   0, 16'h0, 16'h0, 1, 16'h6060));

        // Reset during a fill abandons it and invalidates lines.
        bus.Rd   = 1'b1;
        bus.Addr = 16'h0080;
        tick();
        bus.Rd = 1'b0;
        chk("mid fill req", 16'(bus.mem_req), 16'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async rst stall", 16'(bus.Stall), 16'd0);
        chk("async rst req",   16'(bus.mem_req), 16'd0);
        chk("async rst maddr", bus.mem_addr, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        run(12, mk(1, 0, 16'h0080, 16'h0, 1, 0, 0, 16'h0, 16'h0,
                   1, 16'h0080, 16'h8080, 0, 16'h8080));
        run(13, mk(1, 0, 16'h0060, 16'h0, 0, 0, 0, 16'h0, 16'h0,
                   1, 16'h0060, 16'h6161, 0, 16'h6161));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
